// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, instruction field slices and IF/ID FSM encoding
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } stage_state_e;

  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  function automatic logic is_jump(input logic [31:0] w);
    return (w[OPC_MSB:OPC_LSB] == OP_J) || (w[OPC_MSB:OPC_LSB] == OP_JAL);
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - PC-block, branch-resolution and IF/ID signals of the fetch/decode stage
interface if_id_stage_if #(
  parameter int AW = 16,
  parameter int IW = 32
);
  logic [IW-1:0] ins;
  logic [AW-1:0] current_address;
  logic          ex_branch_taken;
  logic [AW-1:0] ex_branch_target;
  logic [AW-1:0] jmp_loc;
  logic          pc_mux_sel;
  logic          stall;
  logic          stall_pm;
  logic [IW-1:0] id_ins;
  logic [AW-1:0] id_pc;
  logic          id_valid;

  modport slave (
    input  ins, current_address, ex_branch_taken, ex_branch_target,
    output jmp_loc, pc_mux_sel, stall, stall_pm, id_ins, id_pc, id_valid
  );

  modport master (
    output ins, current_address, ex_branch_taken, ex_branch_target,
    input  jmp_loc, pc_mux_sel, stall, stall_pm, id_ins, id_pc, id_valid
  );
endinterface

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags a fetched instruction that reads the rt of a LW sitting in ID
module load_use_detect
  import mips_pkg::*;
#(
  parameter int IW = 32
) (
  input  logic [IW-1:0] id_ins,
  input  logic          id_valid,
  input  logic [IW-1:0] ins,
  output logic          hazard
);

  logic [4:0] ld_rt;
  logic       unused_fields;

  assign ld_rt = id_ins[RT_MSB:RT_LSB];

  // $0 is hardwired to zero, so a load into it never creates a dependency
  assign hazard = id_valid
               && (id_ins[OPC_MSB:OPC_LSB] == OP_LW)
               && (ld_rt != 5'd0)
               && ((ld_rt == ins[RS_MSB:RS_LSB]) || (ld_rt == ins[RT_MSB:RT_LSB]));

  assign unused_fields = ^{id_ins[RS_MSB:RS_LSB], id_ins[IMM_MSB:IMM_LSB],
                           ins[OPC_MSB:OPC_LSB], ins[IMM_MSB:IMM_LSB]};

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with fetch-time jump, load-use stall and branch squash
module if_id_stage
  import mips_pkg::*;
#(
  parameter int AW = 16,
  parameter int IW = 32
) (
  input logic clk,
  input logic reset,
  if_id_stage_if.slave bus
);

  stage_state_e  state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [IW-1:0] id_ins_q, id_ins_d;
  logic [AW-1:0] id_pc_q, id_pc_d;
  logic          id_valid_q, id_valid_d;
  logic          stall_pm_q;
  logic          hazard;
  logic          mux_sel;
  logic [AW-1:0] redirect;
  logic          stall;

  load_use_detect #(.IW(IW)) u_load_use_detect (
    .id_ins  (id_ins_q),
    .id_valid(id_valid_q),
    .ins     (bus.ins),
    .hazard  (hazard)
  );

  // A bubble keeps the fetch address so the replayed instruction inherits it in STALL
  always_comb begin
    state_d    = state_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    mux_sel    = 1'b0;
    redirect   = '0;
    stall      = 1'b0;
    if (!reset) begin
      state_d = ST_BOOT;
    end else if (bus.ex_branch_taken) begin
      mux_sel    = 1'b1;
      redirect   = bus.ex_branch_target;
      id_ins_d   = '0;
      id_pc_d    = pc_q;
      id_valid_d = 1'b0;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hazard) begin
            stall      = 1'b1;
            id_ins_d   = '0;
            id_pc_d    = pc_q;
            id_valid_d = 1'b0;
            state_d    = ST_STALL;
          end else begin
            id_ins_d   = bus.ins;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            if (is_jump(bus.ins)) begin
              mux_sel  = 1'b1;
              redirect = AW'(bus.ins[IMM_MSB:IMM_LSB]);
            end
          end
        end
        ST_STALL: begin
          id_ins_d   = bus.ins;
          id_valid_d = 1'b1;
          state_d    = ST_RUN;
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      id_ins_q   <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      stall_pm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= bus.current_address;
      id_ins_q   <= id_ins_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      stall_pm_q <= stall;
    end
  end

  assign bus.jmp_loc    = redirect;
  assign bus.pc_mux_sel = mux_sel;
  assign bus.stall      = stall;
  assign bus.stall_pm   = stall_pm_q;
  assign bus.id_ins     = id_ins_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_valid   = id_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed vectors for if_id_stage with hand-computed expectations
module tb_if_id_stage;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  if_id_stage_if #(.AW(16), .IW(32)) ifc ();

  if_id_stage #(.AW(16), .IW(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] a, input logic [31:0] w, input logic br, input logic [15:0] t);
    @(negedge clk);
    ifc.current_address  = a;
    ifc.ins              = w;
    ifc.ex_branch_taken  = br;
    ifc.ex_branch_target = t;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic [31:0] w, input logic [15:0] pc);
    chk({tag, ".valid"}, 64'(ifc.id_valid), 64'd1);
    chk({tag, ".ins"}, 64'(ifc.id_ins), 64'(w));
    chk({tag, ".pc"}, 64'(ifc.id_pc), 64'(pc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".id_ins"}, 64'(ifc.id_ins), 64'd0);
    chk({tag, ".id_pc"}, 64'(ifc.id_pc), 64'd0);
    chk({tag, ".id_valid"}, 64'(ifc.id_valid), 64'd0);
    chk({tag, ".stall_pm"}, 64'(ifc.stall_pm), 64'd0);
    chk({tag, ".stall"}, 64'(ifc.stall), 64'd0);
    chk({tag, ".pc_mux_sel"}, 64'(ifc.pc_mux_sel), 64'd0);
    chk({tag, ".jmp_loc"}, 64'(ifc.jmp_loc), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    ifc.current_address  = 16'h0007;
    ifc.ins              = 32'h08000077;
    ifc.ex_branch_taken  = 1'b0;
    ifc.ex_branch_target = 16'h0000;
    #3;
    chk_reset_vals("reset");

    // BOOT: duplicate word 0 is discarded, no jump decode
    @(negedge clk);
    reset = 1'b1;
    ifc.current_address = 16'h0000;
    ifc.ins             = 32'h11111111;
    #1;
    chk("boot.stall", 64'(ifc.stall), 64'd0);
    edge_settle();
    chk("boot.id_valid", 64'(ifc.id_valid), 64'd0);

    put(16'h0001, 32'h11111111, 1'b0, 16'h0);
    edge_settle();
    chk_id("word0", 32'h11111111, 16'h0000);
    put(16'h0002, 32'h22222222, 1'b0, 16'h0);
    edge_settle();
    chk_id("word1", 32'h22222222, 16'h0001);

    // NOP at address 2 is a valid instruction
    put(16'h0005, 32'h00000000, 1'b0, 16'h0);
    edge_settle();
    chk_id("nop", 32'h00000000, 16'h0002);

    // J 0x0040 fetched from address 5
    put(16'h0040, 32'h08000040, 1'b0, 16'h0);
    chk("j.pc_mux_sel", 64'(ifc.pc_mux_sel), 64'd1);
    chk("j.jmp_loc", 64'(ifc.jmp_loc), 64'h40);
    chk("j.stall", 64'(ifc.stall), 64'd0);
    edge_settle();
    chk_id("j.id", 32'h08000040, 16'h0005);
    put(16'h0041, 32'h12345678, 1'b0, 16'h0);
    chk("j_tgt.pc_mux_sel", 64'(ifc.pc_mux_sel), 64'd0);
    edge_settle();
    chk_id("j_tgt", 32'h12345678, 16'h0040);

    // LW $8 then ADD $9,$8,$1
    put(16'h0042, 32'h8C080000, 1'b0, 16'h0);
    edge_settle();
    chk_id("lw8", 32'h8C080000, 16'h0041);
    put(16'h0043, 32'h01014820, 1'b0, 16'h0);
    chk("lu.stall", 64'(ifc.stall), 64'd1);
    chk("lu.pc_mux_sel", 64'(ifc.pc_mux_sel), 64'd0);
    edge_settle();
    chk("lu.bubble", 64'(ifc.id_valid), 64'd0);
    chk("lu.stall_pm", 64'(ifc.stall_pm), 64'd1);
    put(16'h0043, 32'h01014820, 1'b0, 16'h0);
    chk("lu_replay.stall", 64'(ifc.stall), 64'd0);
    edge_settle();
    chk_id("lu_replay", 32'h01014820, 16'h0042);
    chk("lu_replay.stall_pm", 64'(ifc.stall_pm), 64'd0);

    // LW $0 followed by a reader of $0: no hazard
    put(16'h0044, 32'h00000000, 1'b0, 16'h0);
    edge_settle();
    put(16'h0045, 32'h8C000000, 1'b0, 16'h0);
    edge_settle();
    chk_id("lw0", 32'h8C000000, 16'h0044);
    put(16'h0046, 32'h00004820, 1'b0, 16'h0);
    chk("lw0.stall", 64'(ifc.stall), 64'd0);
    edge_settle();
    chk_id("lw0_reader", 32'h00004820, 16'h0045);

    // Taken branch beats a J on ins
    put(16'h0100, 32'h08000040, 1'b1, 16'h0100);
    chk("br.jmp_loc", 64'(ifc.jmp_loc), 64'h100);
    chk("br.pc_mux_sel", 64'(ifc.pc_mux_sel), 64'd1);
    chk("br.stall", 64'(ifc.stall), 64'd0);
    edge_settle();
    chk("br.bubble", 64'(ifc.id_valid), 64'd0);
    put(16'h0101, 32'hAAAA0001, 1'b0, 16'h0);
    edge_settle();
    chk_id("br_tgt", 32'hAAAA0001, 16'h0100);

    // Branch arriving in the STALL cycle
    put(16'h0102, 32'h8C080000, 1'b0, 16'h0);
    edge_settle();
    put(16'h0103, 32'h01014820, 1'b0, 16'h0);
    chk("brst.hazard_stall", 64'(ifc.stall), 64'd1);
    edge_settle();
    put(16'h0200, 32'h01014820, 1'b1, 16'h0200);
    chk("brst.stall", 64'(ifc.stall), 64'd0);
    chk("brst.pc_mux_sel", 64'(ifc.pc_mux_sel), 64'd1);
    chk("brst.jmp_loc", 64'(ifc.jmp_loc), 64'h200);
    edge_settle();
    chk("brst.bubble", 64'(ifc.id_valid), 64'd0);
    chk("brst.stall_pm", 64'(ifc.stall_pm), 64'd0);
    put(16'h0077, 32'h08000077, 1'b0, 16'h0);
    chk("brst.run_jump", 64'(ifc.pc_mux_sel), 64'd1);
    chk("brst.run_jmp_loc", 64'(ifc.jmp_loc), 64'h77);
    edge_settle();
    chk_id("brst_tgt", 32'h08000077, 16'h0200);

    // Reset asserted in the middle of a STALL cycle
    put(16'h0078, 32'h8C080000, 1'b0, 16'h0);
    edge_settle();
    put(16'h0079, 32'h00284820, 1'b0, 16'h0);
    chk("rst.hazard_rt", 64'(ifc.stall), 64'd1);
    edge_settle();
    chk("rst.stall_pm_before", 64'(ifc.stall_pm), 64'd1);
    ifc.ins              = 32'h08000077;
    ifc.ex_branch_taken  = 1'b1;
    ifc.ex_branch_target = 16'h0300;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");

    @(negedge clk);
    reset = 1'b1;
    ifc.current_address  = 16'h0000;
    ifc.ins              = 32'h11111111;
    ifc.ex_branch_taken  = 1'b0;
    ifc.ex_branch_target = 16'h0000;
    edge_settle();
    chk("rst_boot.id_valid", 64'(ifc.id_valid), 64'd0);
    chk("rst_boot.stall_pm", 64'(ifc.stall_pm), 64'd0);
    put(16'h0001, 32'h11111111, 1'b0, 16'h0);
    edge_settle();
    chk_id("rst_word0", 32'h11111111, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-to-decode stage directly downstream of the program-memory/PC block. Captures each fetched instruction and its address into the IF/ID pipeline register, and resolves control flow at fetch. Drives the PC block's `jmp_loc`, `pc_mux_sel`, `stall` and `stall_pm` inputs for three cases:

- unconditional jumps, with zero bubbles;
- taken execute-stage branches, by squashing wrong-path instructions;
- load-use hazards, with a one-cycle stall.

## Interface
- `AW`, 16, instruction address width
- `IW`, 32, instruction width
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset; 0 = in reset
- `ins`  in  IW  instruction from program memory; it is the word at the address driven one cycle earlier
- `current_address`  in  AW  PC presented to program memory this cycle
- `ex_branch_taken`  in  1  execute stage resolved a taken branch this cycle
- `ex_branch_target`  in  AW  target for `ex_branch_taken`
- `jmp_loc`  out  AW  redirect address to the PC block
- `pc_mux_sel`  out  1  selects `jmp_loc` as the next PC
- `stall`  out  1  PC holds (refetches the previous address)
- `stall_pm`  out  1  PC block replays its previous instruction
- `id_ins`  out  IW  IF/ID instruction
- `id_pc`  out  AW  address of `id_ins`
- `id_valid`  out  1  `id_ins` is a real instruction; 0 = bubble

## Operation
**Address pairing**
- `pc_q` registers `current_address` every cycle.
- `ins` in cycle t is the word at `pc_q`.

**FSM states**
- BOOT (reset state):
  - Discards the first `ins` after reset release, because the PC block re-presents address 0 and that word arrives twice.
  - Unconditionally goes to RUN after 1 cycle.
- RUN: normal capture.
  - The IF/ID register loads `ins`/`pc_q` with `id_valid`=1.
  - Goes to STALL on a load-use hazard.
- STALL: one cycle.
  - `stall_pm`=1.
  - Returns to RUN.

**Fetch jump (RUN only)**
- Triggered when `ins[31:26]` is 000010 (J) or 000011 (JAL).
- Combinationally, the same cycle: `pc_mux_sel`=1 and `jmp_loc`=`ins[15:0]`.
- The jump instruction itself is loaded into ID (JAL needs `id_pc` for the link value).

**Load-use hazard (RUN only)**
- Condition: `id_valid`, `id_ins[31:26]`=100011 (LW), `id_ins[20:16]`≠0, and that register equals `ins[25:21]` or `ins[20:16]`.
- Response in the same cycle:
  - `stall`=1;
  - ID loads a bubble (`id_valid`=0);
  - any jump decode on `ins` is suppressed.
- In the following STALL cycle, the replayed instruction is loaded normally.

**Taken branch (any state, highest priority)**
- `pc_mux_sel`=1 and `jmp_loc`=`ex_branch_target`.
- `ins` this cycle is squashed.
- ID loads a bubble: the instruction currently in ID is wrong-path.
- Next state is RUN.
- `stall` is forced 0 and no STALL entry occurs.

**Output and priority rules**
- `stall` and `pc_mux_sel` are never both 1.
- Priority order: branch > load-use > jump.
- `ins`=0 (NOP) is captured as a valid instruction.
- Address arithmetic is mod 2^AW. Jump targets are the 16-bit field taken verbatim; no sign extension.

## Timing
**Reset values** (asynchronous, while `reset`=0)
- State BOOT.
- `id_ins`=0, `id_pc`=0, `id_valid`=0, `pc_q`=0.
- `stall_pm`=0, `stall`=0, `pc_mux_sel`=0, `jmp_loc`=0.
- Reset asserted mid-operation returns to BOOT immediately and discards any pending STALL.

**Output timing**
- `jmp_loc`, `pc_mux_sel` and `stall` are combinational from `ins`, ID state and the branch inputs.
- `stall_pm` is registered: it is high exactly in the cycle after `stall`.

**Latency**
- `ins` in cycle t appears on `id_ins` from cycle t+1.
- Jump cost: 0 bubbles (target word arrives at t+1).
- Load-use cost: 1 bubble.
- Taken-branch cost: 2 bubbles (ID and IF slots).

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: `OP_J`=000010, `OP_JAL`=000011, `OP_LW`=100011, `OP_RTYPE`=000000;
  - field slice constants for opcode, rs, rt and `imm`;
  - FSM state encoding: BOOT, RUN, STALL.
- One sub-module: `load_use_detect`, purely combinational. Inputs: `id_ins`, `id_valid`, `ins`. Output: `hazard`.
- FSM, IF/ID register and redirect mux live in `if_id_stage`.

## Test plan
- **Reset then release, memory holds 0x11111111 at address 0 and 0x22222222 at 1:**
  - BOOT cycle discards the duplicate word;
  - `id_ins` sequence 0x11111111 (`id_pc`=0), then 0x22222222 (`id_pc`=1);
  - no duplicate.
- **J with `imm`=0x0040 arriving at address 5:**
  - same cycle `pc_mux_sel`=1, `jmp_loc`=0x0040;
  - next `id_ins` after the J has `id_pc`=0x0040.
- **LW $8 in ID, then `ins` = ADD reading rs=$8:**
  - `stall`=1 for 1 cycle, `stall_pm`=1 the next cycle;
  - ID shows bubble then the ADD, with unchanged `id_pc`.
- **LW $0 in ID followed by a reader of $0:**
  - no stall.
- **`ex_branch_taken`=1, target 0x0100, while a J is on `ins`:**
  - `jmp_loc`=0x0100;
  - two bubbles;
  - next valid `id_pc`=0x0100.
- **Branch during a load-use stall cycle, and reset asserted during STALL:**
  - branch: `stall`=0, redirect wins, FSM returns to RUN;
  - reset: all outputs return to their reset values asynchronously.
